axi_record_packer: RTL

//  Transmit-side counterpart of the per-channel AXIS record unpacker. Pops C_SORTER_BIT_WIDTH records

---
 rtl/merger_pkg.sv | 24 ++
 rtl/axis_out_reg.sv | 39 +++
 rtl/axi_record_packer.sv | 97 +++++++++
 3 files changed

// File: rtl/merger_pkg.sv
// Shared definitions for the merger-tree output stage: width defaults and
// lane/keep helpers used by the record packer.
package merger_pkg;

  localparam int DEF_SORTER_BIT_WIDTH = 32;
  localparam int LP_KEY_WIDTH         = 32;
  // Widest keep vector the helper can describe (1024-bit stream).
  localparam int LP_MAX_KEEP          = 128;

  function automatic int num_lanes(input int tdata_w, input int rec_w);
    return tdata_w / rec_w;
  endfunction

  // Byte-enable mask for cnt filled lanes, lowest lanes first.
  function automatic logic [LP_MAX_KEEP-1:0] lane_keep(input int cnt, input int bytes_per_lane);
    logic [LP_MAX_KEEP-1:0] mask;
    mask = '0;
    for (int i = 0; i < LP_MAX_KEEP; i++) begin
      mask[i] = (i < cnt * bytes_per_lane);
    end
    return mask;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-deep AXI4-Stream output register. Loads a beat on load and holds it
// stable until the sink accepts it.
module axis_out_reg
  import merger_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] tdata,
  input  logic [KEEP_W-1:0] tkeep,
  input  logic              tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast
);

  // load is only raised when the register is empty or draining this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= tdata;
      m_axis_tkeep  <= tkeep;
      m_axis_tlast  <= tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_record_packer.sv
// Packs records popped from a show-ahead FIFO into AXI4-Stream beats, closing
// a partial beat with TKEEP/TLAST when the stream-last record arrives.
module axi_record_packer
  import merger_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_SORTER_BIT_WIDTH = DEF_SORTER_BIT_WIDTH
) (
  input  logic                            m_axis_aclk,
  input  logic                            m_axis_areset,
  input  logic                            i_fifo_empty,
  input  logic [C_SORTER_BIT_WIDTH-1:0]   i_fifo_data,
  input  logic                            i_fifo_last,
  output logic                            o_fifo_deq,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic [31:0]                     o_beat_count,
  output logic                            o_idle
);

  localparam int LP_NUM_LOOPS = num_lanes(C_AXIS_TDATA_WIDTH, C_SORTER_BIT_WIDTH);
  localparam int LP_KEEP_W    = C_AXIS_TDATA_WIDTH / 8;
  localparam int LP_BYTES     = C_SORTER_BIT_WIDTH / 8;
  localparam int LP_CNT_W     = $clog2(LP_NUM_LOOPS + 1);

  if ((C_AXIS_TDATA_WIDTH % C_SORTER_BIT_WIDTH) != 0 || (C_SORTER_BIT_WIDTH % 8) != 0 ||
      LP_KEEP_W > LP_MAX_KEEP) begin : g_param_check
    $error("axi_record_packer: unsupported C_AXIS_TDATA_WIDTH / C_SORTER_BIT_WIDTH combination");
  end

  logic [C_AXIS_TDATA_WIDTH-1:0] acc_data;
  logic [LP_CNT_W-1:0]           cnt;
  logic                          acc_last;
  logic                          acc_full;
  logic                          move;
  logic [LP_CNT_W-1:0]           wr_lane;
  logic [LP_KEEP_W-1:0]          acc_keep;

  assign move       = acc_full & (~m_axis_tvalid | m_axis_tready);
  assign o_fifo_deq = ~i_fifo_empty & (~acc_full | move) & ~m_axis_areset;
  // A pop on a move edge starts the fresh beat at lane 0.
  assign wr_lane    = move ? '0 : cnt;
  assign acc_keep   = LP_KEEP_W'(lane_keep(int'(cnt), LP_BYTES));
  assign o_idle     = (cnt == '0) & ~acc_full & ~m_axis_tvalid;

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      acc_data     <= '0;
      cnt          <= '0;
      acc_last     <= 1'b0;
      acc_full     <= 1'b0;
      o_beat_count <= '0;
    end else begin
      if (m_axis_tvalid & m_axis_tready) begin
        o_beat_count <= o_beat_count + 32'd1;
      end
      if (move) begin
        acc_data <= '0;
        cnt      <= '0;
        acc_last <= 1'b0;
        acc_full <= 1'b0;
      end
      // Later assignments win, so a pop overrides its lane of the clear above.
      if (o_fifo_deq) begin
        for (int l = 0; l < LP_NUM_LOOPS; l++) begin
          if (wr_lane == LP_CNT_W'(l)) begin
            acc_data[l*C_SORTER_BIT_WIDTH +: C_SORTER_BIT_WIDTH] <= i_fifo_data;
          end
        end
        cnt      <= wr_lane + LP_CNT_W'(1);
        acc_last <= i_fifo_last;
        acc_full <= i_fifo_last | (wr_lane == LP_CNT_W'(LP_NUM_LOOPS - 1));
      end
    end
  end

  axis_out_reg #(
    .DATA_W (C_AXIS_TDATA_WIDTH),
    .KEEP_W (LP_KEEP_W)
  ) u_out_reg (
    .clk           (m_axis_aclk),
    .rst           (m_axis_areset),
    .load          (move),
    .tdata         (acc_data),
    .tkeep         (acc_keep),
    .tlast         (acc_last),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast)
  );

endmodule
